// File: rtl/ieee_conv_pkg.sv
// Shared definitions for the binary <-> IEEE-style converters: widths, bias,
// FSM state encoding and the round-to-nearest-even decision helper.
package ieee_conv_pkg;

  localparam int INT_W_DEFAULT  = 8;
  localparam int FRAC_W_DEFAULT = 8;
  localparam int MAN_W_DEFAULT  = 8;
  localparam int EXP_W_DEFAULT  = 8;
  localparam int BIAS_DEFAULT   = 127;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    LOAD = 3'd1,
    SHR  = 3'd2,
    SHL  = 3'd3,
    DONE = 3'd4
  } state_t;

  // Round-to-nearest-even: round up when past half-way, or exactly half-way
  // with an odd LSB.
  function automatic logic rne_round_up(input logic lsb, input logic guard, input logic sticky);
    return guard & (sticky | lsb);
  endfunction

endpackage

// File: rtl/ieee_round.sv
// Combinational round-to-nearest-even of a normalised mantissa.
// A carry out of the mantissa wraps it to zero and bumps the exponent
// (the hidden bit moves up one position).
module ieee_round
  import ieee_conv_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEFAULT,
  parameter int EXP_W = EXP_W_DEFAULT
) (
  input  logic [MAN_W-1:0] man_in,
  input  logic             guard,
  input  logic             sticky,
  input  logic [EXP_W-1:0] exp_in,
  output logic [MAN_W-1:0] man_out,
  output logic [EXP_W-1:0] exp_out
);

  localparam logic [MAN_W:0]   MAN_ZERO_EXT = {(MAN_W+1){1'b0}};
  localparam logic [EXP_W-1:0] EXP_ONE      = EXP_W'(1);

  logic           round_up_s;
  logic [MAN_W:0] man_sum_s;

  // Apply the rounding increment and handle the mantissa carry-out
  always_comb begin
    round_up_s = rne_round_up(man_in[0], guard, sticky);
    man_sum_s  = {1'b0, man_in} + {MAN_ZERO_EXT[MAN_W:1], round_up_s};
    if (man_sum_s[MAN_W]) begin
      man_out = {MAN_W{1'b0}};
      exp_out = exp_in + EXP_ONE;
    end else begin
      man_out = man_sum_s[MAN_W-1:0];
      exp_out = exp_in;
    end
  end

endmodule

// File: rtl/bin_to_ieee.sv
// Unsigned fixed-point {decimal_portion.fraction_portion} to biased exponent +
// hidden-bit mantissa. Normalises one shift per clock under a small FSM.
// Optional feature macro: ROUND_NEAREST_EN (round-to-nearest-even on the
// right-shift path); when undefined the mantissa is truncated.
module bin_to_ieee
  import ieee_conv_pkg::*;
#(
  parameter int INT_W  = INT_W_DEFAULT,
  parameter int FRAC_W = FRAC_W_DEFAULT,
  parameter int MAN_W  = MAN_W_DEFAULT,
  parameter int EXP_W  = EXP_W_DEFAULT,
  parameter int BIAS   = BIAS_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [INT_W-1:0]  decimal_portion,
  input  logic [FRAC_W-1:0] fraction_portion,
  output logic [MAN_W-1:0]  mantissa,
  output logic [EXP_W-1:0]  exponent,
  output logic              zero,
  output logic              busy,
  output logic              done
);

  localparam int V_W = INT_W + FRAC_W;
  localparam logic [INT_W-1:0] DEC_ONE  = INT_W'(1);
  localparam logic [EXP_W:0]   E_ONE    = (EXP_W+1)'(1);
  localparam logic [EXP_W:0]   E_BIAS   = (EXP_W+1)'(BIAS);
  localparam logic [V_W-1:0]   V_ZERO   = {V_W{1'b0}};

  state_t           state_r, state_nxt;
  logic [V_W-1:0]   v_r, v_nxt;
  logic [EXP_W:0]   e_r, e_nxt;
  logic [INT_W-1:0] dec_s, dec_nxt_s;
  logic             res_zero_s;
  logic [MAN_W-1:0] res_man_s;
  logic [EXP_W-1:0] res_exp_s;

  logic [MAN_W-1:0] mantissa_r;
  logic [EXP_W-1:0] exponent_r;
  logic             zero_r, busy_r, done_r;

  assign dec_s     = v_r[V_W-1:FRAC_W];
  assign dec_nxt_s = v_nxt[V_W-1:FRAC_W];

  // Next-state and datapath update: capture, classify, then shift until the
  // leading 1 sits just above the binary point
  always_comb begin
    state_nxt  = state_r;
    v_nxt      = v_r;
    e_nxt      = e_r;
    res_zero_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nxt = LOAD;
          v_nxt     = {decimal_portion, fraction_portion};
          e_nxt     = E_BIAS;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        if (v_r == V_ZERO) begin
          state_nxt  = DONE;
          e_nxt      = {(EXP_W+1){1'b0}};
          res_zero_s = 1'b1;
        end else if (dec_s == DEC_ONE) begin
          state_nxt = DONE;
        end else if (dec_s > DEC_ONE) begin
          state_nxt = SHR;
        end else begin
          state_nxt = SHL;
        end
      end
      SHR: begin
        v_nxt = v_r >> 1;
        e_nxt = e_r + E_ONE;
        if (dec_nxt_s == DEC_ONE) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHR;
        end
      end
      SHL: begin
        v_nxt = v_r << 1;
        e_nxt = e_r - E_ONE;
        if (v_nxt[FRAC_W]) begin
          state_nxt = DONE;
        end else begin
          state_nxt = SHL;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State and working-value registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      v_r     <= V_ZERO;
      e_r     <= {(EXP_W+1){1'b0}};
    end else begin
      state_r <= state_nxt;
      v_r     <= v_nxt;
      e_r     <= e_nxt;
    end
  end

`ifdef ROUND_NEAREST_EN
  logic guard_r, guard_nxt, sticky_r, sticky_nxt;

  // Guard is the most recent bit shifted out; sticky ORs all earlier ones.
  // Both are cleared on capture and only change while right-shifting.
  always_comb begin
    guard_nxt  = guard_r;
    sticky_nxt = sticky_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          guard_nxt  = 1'b0;
          sticky_nxt = 1'b0;
        end else begin
          guard_nxt  = guard_r;
          sticky_nxt = sticky_r;
        end
      end
      SHR: begin
        guard_nxt  = v_r[0];
        sticky_nxt = sticky_r | guard_r;
      end
      default: begin
        guard_nxt  = guard_r;
        sticky_nxt = sticky_r;
      end
    endcase
  end

  // Guard/sticky registers
  always_ff @(posedge clk) begin
    if (rst) begin
      guard_r  <= 1'b0;
      sticky_r <= 1'b0;
    end else begin
      guard_r  <= guard_nxt;
      sticky_r <= sticky_nxt;
    end
  end

  ieee_round #(
    .MAN_W (MAN_W),
    .EXP_W (EXP_W)
  ) u_round (
    .man_in  (v_nxt[FRAC_W-1 -: MAN_W]),
    .guard   (guard_nxt),
    .sticky  (sticky_nxt),
    .exp_in  (e_nxt[EXP_W-1:0]),
    .man_out (res_man_s),
    .exp_out (res_exp_s)
  );
`else
  assign res_man_s = v_nxt[FRAC_W-1 -: MAN_W];
  assign res_exp_s = e_nxt[EXP_W-1:0];
`endif

  // Registered outputs: the result is latched on entry to DONE so it is valid
  // in the same cycle as the done pulse, and held until the next result
  always_ff @(posedge clk) begin
    if (rst) begin
      mantissa_r <= {MAN_W{1'b0}};
      exponent_r <= {EXP_W{1'b0}};
      zero_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      busy_r <= (state_nxt != IDLE);
      done_r <= (state_nxt == DONE);
      if (state_nxt == DONE) begin
        mantissa_r <= res_man_s;
        exponent_r <= res_exp_s;
        zero_r     <= res_zero_s;
      end else begin
        mantissa_r <= mantissa_r;
        exponent_r <= exponent_r;
        zero_r     <= zero_r;
      end
    end
  end

  assign mantissa = mantissa_r;
  assign exponent = exponent_r;
  assign zero     = zero_r;
  assign busy     = busy_r;
  assign done     = done_r;

endmodule

// File: tb/tb_bin_to_ieee.sv
// Directed self-checking bench for bin_to_ieee. Inputs change 1 time unit
// after posedge; outputs are sampled at the same point.
module tb_bin_to_ieee;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] decimal_portion = 8'h00;
  logic [7:0] fraction_portion = 8'h00;
  logic [7:0] mantissa;
  logic [7:0] exponent;
  logic       zero, busy, done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bin_to_ieee dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .decimal_portion  (decimal_portion),
    .fraction_portion (fraction_portion),
    .mantissa         (mantissa),
    .exponent         (exponent),
    .zero             (zero),
    .busy             (busy),
    .done             (done)
  );

  // Input value truncated to 9 significant bits (hidden 1 + 8 mantissa bits)
  function automatic logic [15:0] trunc9(input logic [15:0] v);
    int p = 15;
    logic [15:0] ones = 16'hFFFF;
    while (p > 0 && !v[p]) p--;
    if (p > 8) return v & (ones << (p - 8));
    else return v;
  endfunction

  // Rebuild the 8.8 fixed-point value an IEEE-to-binary converter would produce
  function automatic logic [15:0] recon(input logic [7:0] e, input logic [7:0] m);
    logic [31:0] s;
    s = {23'd0, 1'b1, m};
    if (int'(e) >= 127) s = s << (int'(e) - 127);
    else s = s >> (127 - int'(e));
    return s[15:0];
  endfunction

  // Pulse start for one cycle; returns just after the sampling edge
  task automatic do_start(input logic [7:0] d, input logic [7:0] f);
    @(posedge clk); #1;
    decimal_portion  = d;
    fraction_portion = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Wait (bounded) for done; lat counts clocks from the start cycle
  task automatic wait_done(output int lat);
    lat = 1;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_tests++; if (mantissa !== 8'h00) begin n_fail++; $display("FAIL reset_mantissa got %h want 00", mantissa); end
    n_tests++; if (exponent !== 8'h00) begin n_fail++; $display("FAIL reset_exponent got %h want 00", exponent); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL reset_zero got %b want 0", zero); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
  endtask

  task automatic test_convert(input string name, input logic [7:0] d, input logic [7:0] f,
                              input logic [7:0] e_exp, input logic [7:0] m_exp,
                              input logic z_exp, input int lat_exp, input bit check_rt);
    int lat;
    do_start(d, f);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy got %b want 1", name, busy); end
    wait_done(lat);
    n_tests++;
    if (!done) begin
      n_fail++; $display("FAIL %s_timeout no done within %0d clocks", name, lat);
    end else begin
      n_tests++; if (lat != lat_exp) begin n_fail++; $display("FAIL %s_latency got %0d want %0d", name, lat, lat_exp); end
      n_tests++; if (exponent !== e_exp) begin n_fail++; $display("FAIL %s_exponent got %0d want %0d", name, exponent, e_exp); end
      n_tests++; if (mantissa !== m_exp) begin n_fail++; $display("FAIL %s_mantissa got %h want %h", name, mantissa, m_exp); end
      n_tests++; if (zero !== z_exp) begin n_fail++; $display("FAIL %s_zero got %b want %b", name, zero, z_exp); end
      if (check_rt) begin
        n_tests++;
        if (recon(exponent, mantissa) !== trunc9({d, f})) begin
          n_fail++; $display("FAIL %s_roundtrip got %h want %h", name, recon(exponent, mantissa), trunc9({d, f}));
        end
      end
      @(posedge clk); #1;
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_busy got %b want 0", name, busy); end
      n_tests++; if (exponent !== e_exp) begin n_fail++; $display("FAIL %s_hold got %0d want %0d", name, exponent, e_exp); end
    end
  endtask

  task automatic test_abort();
    int seen = 0;
    do_start(8'h05, 8'h40);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got %b want 0", busy); end
    n_tests++; if (exponent !== 8'h00) begin n_fail++; $display("FAIL abort_exponent got %h want 00", exponent); end
    n_tests++; if (mantissa !== 8'h00) begin n_fail++; $display("FAIL abort_mantissa got %h want 00", mantissa); end
    n_tests++; if (zero !== 1'b0) begin n_fail++; $display("FAIL abort_zero got %b want 0", zero); end
    for (int i = 0; i < 10; i++) begin
      if (done) seen++;
      @(posedge clk); #1;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL abort_no_done got %0d done cycles want 0", seen); end
  endtask

  task automatic test_busy_ignore();
    int seen = 0;
    do_start(8'h01, 8'h80);
    // extra start while in LOAD: must be ignored
    decimal_portion = 8'hFF; fraction_portion = 8'hFF; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (done !== 1'b1) begin n_fail++; $display("FAIL ignore_done got %b want 1", done); end
    n_tests++; if (exponent !== 8'd127) begin n_fail++; $display("FAIL ignore_exponent got %0d want 127", exponent); end
    n_tests++; if (mantissa !== 8'h80) begin n_fail++; $display("FAIL ignore_mantissa got %h want 80", mantissa); end
    // start in the done cycle: FSM is in DONE, so it must be ignored too
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_start_at_done busy got %b want 0", busy); end
    for (int i = 0; i < 12; i++) begin
      if (done || busy) seen++;
      @(posedge clk); #1;
    end
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL ignore_no_queue got %0d active cycles want 0", seen); end
    n_tests++; if (exponent !== 8'd127) begin n_fail++; $display("FAIL ignore_hold got %0d want 127", exponent); end
  endtask

  task automatic test_back_to_back();
    test_convert("b2b_a", 8'h00, 8'h60, 8'd125, 8'h80, 1'b0, 4, 1'b1);
    test_convert("b2b_b", 8'h00, 8'h01, 8'd119, 8'h00, 1'b0, 10, 1'b1);
  endtask

  initial begin
    test_reset();
    test_convert("one_half",  8'h01, 8'h80, 8'd127, 8'h80, 1'b0, 2, 1'b1);
    test_convert("five_q",    8'h05, 8'h40, 8'd129, 8'h50, 1'b0, 4, 1'b1);
    test_convert("frac_3_8",  8'h00, 8'h60, 8'd125, 8'h80, 1'b0, 4, 1'b1);
    test_convert("zero_in",   8'h00, 8'h00, 8'd0,   8'h00, 1'b1, 2, 1'b0);
`ifdef ROUND_NEAREST_EN
    test_convert("all_ones",  8'hFF, 8'hFF, 8'd135, 8'h00, 1'b0, 9, 1'b0);
`else
    test_convert("all_ones",  8'hFF, 8'hFF, 8'd134, 8'hFF, 1'b0, 9, 1'b1);
`endif
    test_convert("exact_one", 8'h01, 8'h00, 8'd127, 8'h00, 1'b0, 2, 1'b1);
    test_convert("min_lsb",   8'h00, 8'h01, 8'd119, 8'h00, 1'b0, 10, 1'b1);
    test_convert("pow2_hi",   8'h80, 8'h00, 8'd134, 8'h00, 1'b0, 9, 1'b1);
    test_convert("half",      8'h00, 8'h80, 8'd126, 8'h00, 1'b0, 3, 1'b1);
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
